// File: rtl/regfile_writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_arbiter_if
// Brief    : Producer handshakes, decode issue, register file write port and
//            pending-write mask shared by the writeback arbiter and its users.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_writeback_arbiter_if #(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic                  alu_valid;
    logic [SEL_W-1:0]      alu_sel;
    logic [DATA_WIDTH-1:0] alu_data;

    logic                  ld_valid;
    logic                  ld_ready;
    logic [SEL_W-1:0]      ld_sel;
    logic [DATA_WIDTH-1:0] ld_data;

    logic                  md_valid;
    logic                  md_ready;
    logic [SEL_W-1:0]      md_sel;
    logic [DATA_WIDTH-1:0] md_data;

    logic                  issue_en;
    logic [SEL_W-1:0]      issue_sel;

    logic                  write_en;
    logic [SEL_W-1:0]      write_sel;
    logic [DATA_WIDTH-1:0] write_data;
    logic [NUM_REGS-1:0]   busy;

    // Producers and decode side
    modport master (
        output alu_valid, alu_sel, alu_data,
        output ld_valid, ld_sel, ld_data,
        input  ld_ready,
        output md_valid, md_sel, md_data,
        input  md_ready,
        output issue_en, issue_sel,
        input  write_en, write_sel, write_data, busy
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_sel, alu_data,
        input  ld_valid, ld_sel, ld_data,
        output ld_ready,
        input  md_valid, md_sel, md_data,
        output md_ready,
        input  issue_en, issue_sel,
        output write_en, write_sel, write_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_arbiter
// Brief    : Merges ALU, load and mul/div results onto the single register
//            file write port (ALU fixed priority, ld/md round-robin).
//            Optional pending-write scoreboard: REGFILE_WB_SCOREBOARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback_arbiter #(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    regfile_writeback_arbiter_if.slave io_wb
);
    localparam int               SEL_W = $clog2(NUM_REGS);
    localparam logic [SEL_W-1:0] c_R0  = '0;

    // Set after a load grant so the next tie goes to mul/div
    logic                  r_rr_md_first;
    logic                  r_write_en;
    logic [SEL_W-1:0]      r_write_sel;
    logic [DATA_WIDTH-1:0] r_write_data;

    logic                  w_ld_grant;
    logic                  w_md_grant;
    logic                  w_xfer;
    logic                  w_commit;
    logic [SEL_W-1:0]      w_sel;
    logic [DATA_WIDTH-1:0] w_data;

    // Grant depends only on valids and the pointer, never on payload
    always_comb begin
        w_ld_grant = 1'b0;
        w_md_grant = 1'b0;
        if (!io_wb.alu_valid) begin
            if (io_wb.ld_valid && io_wb.md_valid) begin
                w_ld_grant = !r_rr_md_first;
                w_md_grant = r_rr_md_first;
            end else begin
                w_ld_grant = io_wb.ld_valid;
                w_md_grant = io_wb.md_valid;
            end
        end
    end

    assign io_wb.ld_ready = w_ld_grant;
    assign io_wb.md_ready = w_md_grant;

    always_comb begin
        w_sel  = io_wb.alu_sel;
        w_data = io_wb.alu_data;
        if (w_ld_grant) begin
            w_sel  = io_wb.ld_sel;
            w_data = io_wb.ld_data;
        end else if (w_md_grant) begin
            w_sel  = io_wb.md_sel;
            w_data = io_wb.md_data;
        end
    end

    assign w_xfer   = io_wb.alu_valid || w_ld_grant || w_md_grant;
    // r0 writes complete the handshake but never reach the register file
    assign w_commit = w_xfer && (w_sel != c_R0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_md_first <= 1'b0;
        end else if (w_ld_grant) begin
            r_rr_md_first <= 1'b1;
        end else if (w_md_grant) begin
            r_rr_md_first <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write_en   <= 1'b0;
            r_write_sel  <= '0;
            r_write_data <= '0;
        end else begin
            r_write_en <= w_commit;
            if (w_commit) begin
                r_write_sel  <= w_sel;
                r_write_data <= w_data;
            end
        end
    end

    assign io_wb.write_en   = r_write_en;
    assign io_wb.write_sel  = r_write_sel;
    assign io_wb.write_data = r_write_data;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
        assign w_set[gi] = (gi != 0) && io_wb.issue_en && (io_wb.issue_sel == SEL_W'(gi));
        assign w_clr[gi] = r_write_en && (r_write_sel == SEL_W'(gi));
    end

    // Set overrides clear so a re-issue in the write cycle stays pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign io_wb.busy = r_busy;
`else
    logic w_unused_issue;
    assign w_unused_issue = &{1'b0, io_wb.issue_en, io_wb.issue_sel};
    assign io_wb.busy     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback_arbiter
// Brief    : Directed and random checks of the writeback arbiter against a
//            grant/write/pending-set reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback_arbiter;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    regfile_writeback_arbiter_if #(.NUM_REGS(16), .DATA_WIDTH(32)) bus ();

    regfile_writeback_arbiter #(.NUM_REGS(16), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_wb (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit          m_last_md;   // last ld/md winner was md -> next tie to ld
    bit          m_we;
    logic [3:0]  m_ws;
    logic [31:0] m_wd;
    bit          m_pend [16];
    bit          ld_acc;
    bit          md_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_md = 1'b1;
        m_we      = 1'b0;
        m_ws      = '0;
        m_wd      = '0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        ld_acc    = 1'b0;
        md_acc    = 1'b0;
    endtask

    function automatic logic [15:0] model_busy();
        logic [15:0] v;
        v = '0;
`ifdef REGFILE_WB_SCOREBOARD_EN
        foreach (m_pend[i]) v[i] = m_pend[i];
`endif
        return v;
    endfunction

    // One clock: check readies, cross the edge, check registered outputs
    task automatic step();
        int          g;   // 0 none, 1 alu, 2 ld, 3 md
        logic [3:0]  s;
        logic [31:0] d;
        bit          iss;
        logic [3:0]  iss_sel;
        #1;
        if (bus.alu_valid)                     g = 1;
        else if (bus.ld_valid && bus.md_valid) g = m_last_md ? 2 : 3;
        else if (bus.ld_valid)                 g = 2;
        else if (bus.md_valid)                 g = 3;
        else                                   g = 0;
        chk("ld_ready", 64'(bus.ld_ready), 64'(g == 2));
        chk("md_ready", 64'(bus.md_ready), 64'(g == 3));
        s = (g == 1) ? bus.alu_sel : (g == 2) ? bus.ld_sel : bus.md_sel;
        d = (g == 1) ? bus.alu_data : (g == 2) ? bus.ld_data : bus.md_data;
        iss     = bus.issue_en;
        iss_sel = bus.issue_sel;
        @(posedge clk);
        if (m_we) m_pend[m_ws] = 1'b0;
        if (iss && iss_sel != 0) m_pend[iss_sel] = 1'b1;
        if (g != 0 && s != 0) begin
            m_we = 1'b1;
            m_ws = s;
            m_wd = d;
        end else begin
            m_we = 1'b0;
        end
        if (g == 2) m_last_md = 1'b0;
        if (g == 3) m_last_md = 1'b1;
        ld_acc = (g == 2);
        md_acc = (g == 3);
        #1;
        chk("write_en",   64'(bus.write_en),   64'(m_we));
        chk("write_sel",  64'(bus.write_sel),  64'(m_ws));
        chk("write_data", 64'(bus.write_data), 64'(m_wd));
        chk("busy",       64'(bus.busy),       64'(model_busy()));
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.md_valid  = 1'b0;
        bus.issue_en  = 1'b0;
    endtask

    task automatic drive_random();
        bus.alu_valid = ($urandom_range(0, 9) < 3);
        bus.alu_sel   = 4'($urandom);
        bus.alu_data  = $urandom;
        if (!(bus.ld_valid && !ld_acc)) begin
            bus.ld_valid = 1'($urandom);
            bus.ld_sel   = 4'($urandom);
            bus.ld_data  = $urandom;
        end
        if (!(bus.md_valid && !md_acc)) begin
            bus.md_valid = 1'($urandom);
            bus.md_sel   = 4'($urandom);
            bus.md_data  = $urandom;
        end
        bus.issue_en  = 1'($urandom);
        bus.issue_sel = 4'($urandom);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        bus.alu_sel = '0; bus.alu_data = '0;
        bus.ld_sel  = '0; bus.ld_data  = '0;
        bus.md_sel  = '0; bus.md_data  = '0;
        bus.issue_sel = '0;
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_write_en",   64'(bus.write_en),   64'd0);
        chk("rst_write_sel",  64'(bus.write_sel),  64'd0);
        chk("rst_write_data", 64'(bus.write_data), 64'd0);
        chk("rst_busy",       64'(bus.busy),       64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness: ld/md held valid, alternation starts with ld
        bus.ld_valid = 1'b1; bus.ld_sel = 4'd6; bus.ld_data = 32'h66;
        bus.md_valid = 1'b1; bus.md_sel = 4'd7; bus.md_data = 32'h77;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fair_ld_ready", 64'(bus.ld_ready), 64'((k % 2) == 0));
            step();
            chk("fair_write_en", 64'(bus.write_en), 64'd1);
        end
        idle();
        step();

        // ALU only
        bus.alu_valid = 1'b1; bus.alu_sel = 4'd3; bus.alu_data = 32'h12345678;
        step();
        chk("alu_we",   64'(bus.write_en),   64'd1);
        chk("alu_sel",  64'(bus.write_sel),  64'd3);
        chk("alu_data", 64'(bus.write_data), 64'h12345678);
        idle();
        step();
        chk("alu_we_off", 64'(bus.write_en), 64'd0);

        // ALU/load collision
        bus.alu_valid = 1'b1; bus.alu_sel = 4'd2; bus.alu_data = 32'hA;
        bus.ld_valid  = 1'b1; bus.ld_sel  = 4'd4; bus.ld_data  = 32'hB;
        #1;
        chk("col_ld_ready", 64'(bus.ld_ready), 64'd0);
        step();
        chk("col_first_sel", 64'(bus.write_sel), 64'd2);
        bus.alu_valid = 1'b0;
        #1;
        chk("col_ld_ready2", 64'(bus.ld_ready), 64'd1);
        step();
        idle();
        step();
        chk("col_second_sel",  64'(bus.write_sel),  64'd4);
        chk("col_second_data", 64'(bus.write_data), 64'hB);
        step();

        // r0 discard
        bus.md_valid = 1'b1; bus.md_sel = 4'd0; bus.md_data = 32'hFFFFFFFF;
        #1;
        chk("r0_md_ready", 64'(bus.md_ready), 64'd1);
        step();
        chk("r0_we",   64'(bus.write_en),   64'd0);
        chk("r0_sel",  64'(bus.write_sel),  64'd4);
        chk("r0_data", 64'(bus.write_data), 64'hB);
        idle();
        step();

        // Scoreboard: issue r5, md writes it five cycles later
        bus.issue_en = 1'b1; bus.issue_sel = 4'd5;
        step();
        bus.issue_en = 1'b0;
`ifdef REGFILE_WB_SCOREBOARD_EN
        chk("sb_set", 64'(bus.busy[5]), 64'd1);
`else
        chk("sb_off", 64'(bus.busy), 64'd0);
`endif
        for (int k = 0; k < 4; k++) step();
        bus.md_valid = 1'b1; bus.md_sel = 4'd5; bus.md_data = 32'h55;
        step();
        idle();
        step();
`ifdef REGFILE_WB_SCOREBOARD_EN
        chk("sb_clr", 64'(bus.busy[5]), 64'd0);
`endif
        // Re-issue in the write_en cycle keeps the bit set
        bus.issue_en = 1'b1; bus.issue_sel = 4'd5;
        step();
        idle();
        bus.md_valid = 1'b1; bus.md_sel = 4'd5; bus.md_data = 32'h56;
        step();
        idle();
        bus.issue_en = 1'b1; bus.issue_sel = 4'd5;
        step();
        idle();
        step();
`ifdef REGFILE_WB_SCOREBOARD_EN
        chk("sb_set_wins", 64'(bus.busy[5]), 64'd1);
`else
        chk("sb_off2", 64'(bus.busy), 64'd0);
`endif

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive_random();
            step();
        end

        // Reset mid-write with both ld and md pending
        idle();
        bus.alu_valid = 1'b1; bus.alu_sel = 4'd9; bus.alu_data = 32'h99;
        bus.ld_valid  = 1'b1; bus.ld_sel  = 4'd1; bus.ld_data  = 32'h11;
        bus.md_valid  = 1'b1; bus.md_sel  = 4'd2; bus.md_data  = 32'h22;
        bus.issue_en  = 1'b1; bus.issue_sel = 4'd9;
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_we", 64'(bus.write_en), 64'd1);
        bus.alu_valid = 1'b0;
        bus.issue_en  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_we",   64'(bus.write_en), 64'd0);
        chk("rst_async_busy", 64'(bus.busy),     64'd0);
        chk("rst_ld_ready",   64'(bus.ld_ready), 64'd1);
        chk("rst_md_ready",   64'(bus.md_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_tie_ld", 64'(ld_acc), 64'd1);
        step();
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/regfile_writeback_arbiter.md
# regfile_writeback_arbiter

Funnels results from the three execution producers (single-cycle ALU, load unit, multi-cycle mul/div) onto the register file's single synchronous write port. The ALU has fixed highest priority. Load and mul/div are arbitrated round-robin through valid/ready handshakes. The write port is driven from flops, and an optional pending-write scoreboard tells decode which registers still have a write outstanding.

## Interface
Parameters:
- NUM_REGS, 16: register count; selects are clog2(NUM_REGS) bits wide.
- DATA_WIDTH, 32: write data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; one clock, asynchronous and active-low.
- alu_valid  in  1  ALU result present; always accepted, no ready.
- alu_sel  in  4  destination register.
- alu_data  in  32  result.
- ld_valid  in  1  load result present.
- ld_ready  out  1  load result accepted this cycle.
- ld_sel  in  4  destination register.
- ld_data  in  32  result.
- md_valid  in  1  mul/div result present.
- md_ready  out  1  mul/div result accepted this cycle.
- md_sel  in  4  destination register.
- md_data  in  32  result.
- issue_en  in  1  decode issues an instruction with a destination register.
- issue_sel  in  4  that destination.
- write_en  out  1  register file write enable.
- write_sel  out  4  register file write select.
- write_data  out  32  register file write data.
- busy  out  16  per-register pending-write mask.

## Operation
- Grant, evaluated combinationally each cycle:
  - alu_valid wins outright; ld_ready=md_ready=0.
  - Else only one of ld/md valid: that one's ready=1.
  - Else both valid: grant the source not granted last (rr pointer).
  - Ready never depends on the source's own data.
  - At most one ready is high in any cycle.
- Round-robin pointer: 1 bit, updates only on a granted ld/md transfer. An ALU grant leaves it unchanged.
- Accepted transfer is registered: write_en<=1, write_sel<=sel, write_data<=data.
  - With no transfer: write_en<=0; write_sel and write_data hold.
- Destination r0: transfer is accepted (ready handshake completes) but write_en<=0 and no scoreboard clear.
- Sources hold sel/data stable while valid && !ready; the block does not check this.

## Timing
- Latency: transfer accepted at edge N drives write_en high for cycle N+1. The register file stores the value at edge N+1.
- Throughput: one write per cycle; there is no internal buffering beyond the output flop.
- Starvation: continuous alu_valid starves ld and md indefinitely. Decode guarantees ALU gaps.
- Reset values:
  - write_en=0, write_sel=0, write_data=0.
  - busy=0.
  - rr pointer favours load (first tie goes to ld).
  - ld_ready and md_ready follow the grant logic, so they are valid during reset.
- Reset mid-operation: a registered write is dropped (write_en forced 0 immediately) and the scoreboard clears. Sources keep their valid and are re-arbitrated after release.

## Configuration
- REGFILE_WB_SCOREBOARD_EN defined:
  - busy[i] sets on the edge where issue_en && issue_sel==i (i≠0).
  - busy[i] clears on the edge ending a cycle with write_en && write_sel==i.
  - Simultaneous set and clear of the same bit: set wins.
  - busy[0] is always 0. busy is registered.
- REGFILE_WB_SCOREBOARD_EN undefined: busy tied to 0; issue_en/issue_sel ignored; no scoreboard flops.

## Test plan
- ALU only: alu_valid, sel=3, data=0x12345678 at edge N -> cycle N+1 write_en=1, write_sel=3, write_data=0x12345678; cycle N+2 write_en=0.
- ALU/load collision: alu(sel 2, 0xA) and ld(sel 4, 0xB) both valid -> ld_ready=0, r2 written first; ld accepted next cycle; r4=0xB written one cycle later.
- Fairness: ld and md held valid continuously, no ALU -> grants alternate ld, md, ld, md starting with ld; write_en high every cycle.
- r0 discard: md_valid, sel=0, data=0xFFFFFFFF -> md_ready=1; write_en stays 0; write_sel/write_data unchanged.
- Scoreboard (macro on): issue r5 -> busy[5]=1 next cycle. md writes r5 5 cycles later -> busy[5]=0 after the write_en edge. Re-issue of r5 in the same cycle as its write_en -> busy[5] stays 1. Macro off -> busy=0 throughout.
- Reset mid-write: assert rst_n=0 while write_en=1 -> write_en=0 and busy=0 asynchronously; after release the first tie goes to ld.
